// File: rtl/riscv_irq_arbiter.sv
// riscv_irq_arbiter
// Gathers the SoC interrupt lines into a pending register (level or rising
// edge per line), picks one enabled pending line and offers it to the core's
// interrupt controller as a pending/id/secure triple. The offer stays frozen
// until the core acks it or the candidate disappears.
// Optional feature macro: RISCV_IRQ_ARB_RR_EN selects round-robin arbitration
// instead of fixed lowest-index priority.
module riscv_irq_arbiter #(
  parameter int          NUM_IRQ   = 32,
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
  parameter logic [31:0] SEC_MASK  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               irq_ack_i,
  output logic               irq_pending_o,
  output logic [4:0]         irq_id_o,
  output logic               irq_sec_o,
  output logic [NUM_IRQ-1:0] irq_pend_vec_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_ACKED = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] cand;
  logic [4:0]         id_q, id_d;
  logic               sec_q, sec_d;
  logic               ack_accept;
  logic               cand_at_id;
  logic               win_found;
  logic [4:0]         win_id;

  assign cand       = pend_q & irq_en_i;
  assign ack_accept = (state_q == ST_OFFER) && irq_ack_i;

  // Is the line currently offered still an enabled, pending candidate?
  always_comb begin
    cand_at_id = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (id_q == 5'(i)) cand_at_id = cand[i];
    end
  end

  // Next pending vector: level lines follow the pin, edge lines set on a
  // rising edge and clear on an accepted ack of that line (set wins).
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        pend_d[i] = (irq_i[i] & ~irq_prev_q[i]) |
                    (pend_q[i] & ~(ack_accept && (id_q == 5'(i))));
      end else begin
        pend_d[i] = irq_i[i];
      end
    end
  end

`ifdef RISCV_IRQ_ARB_RR_EN
  logic [4:0] last_q, last_d;
  int         rr_idx;

  // Round-robin search: start just after the last acked id and wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      rr_idx = int'(last_q) + 1 + k;
      if (rr_idx >= NUM_IRQ) rr_idx = rr_idx - NUM_IRQ;
      if (!win_found && cand[rr_idx]) begin
        win_found = 1'b1;
        win_id    = 5'(rr_idx);
      end
    end
  end

  // The pointer only advances on an accepted ack, never on a withdrawal.
  always_comb begin
    last_d = last_q;
    if (ack_accept) last_d = id_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 5'(NUM_IRQ - 1);
    else        last_q <= last_d;
  end
`else
  // Fixed priority: lowest-index candidate wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!win_found && cand[i]) begin
        win_found = 1'b1;
        win_id    = 5'(i);
      end
    end
  end
`endif

  // Offer FSM: latch a winner in IDLE, hold it in OFFER, blank one cycle after ack.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          sec_d   = SEC_MASK[win_id];
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (irq_ack_i)       state_d = ST_ACKED;
        else if (!cand_at_id) state_d = ST_IDLE;
      end
      ST_ACKED: begin
        sec_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, selection and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      id_q       <= '0;
      sec_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_i;
      pend_q     <= pend_d;
      id_q       <= id_d;
      sec_q      <= sec_d;
    end
  end

  assign irq_pending_o  = (state_q == ST_OFFER);
  assign irq_id_o       = id_q;
  assign irq_sec_o      = sec_q;
  assign irq_pend_vec_o = pend_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// tb_riscv_irq_arbiter
// Directed bench for riscv_irq_arbiter with lines 2 and 5 edge-triggered and
// line 10 secure. Honours RISCV_IRQ_ARB_RR_EN for the arbitration-order test.
module tb_riscv_irq_arbiter;

  localparam int          NUM_IRQ = 32;
  localparam logic [31:0] EDGE    = 32'h0000_0024;
  localparam logic [31:0] SEC     = 32'h0000_0400;

  logic               clk;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irqEn;
  logic               irqAck;
  logic               irqPending;
  logic [4:0]         irqId;
  logic               irqSec;
  logic [NUM_IRQ-1:0] pendVec;

  int assertCount;
  int failCount;

  riscv_irq_arbiter #(
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (EDGE),
    .SEC_MASK  (SEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_i          (irq),
    .irq_en_i       (irqEn),
    .irq_ack_i      (irqAck),
    .irq_pending_o  (irqPending),
    .irq_id_o       (irqId),
    .irq_sec_o      (irqSec),
    .irq_pend_vec_o (pendVec)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_IRQ-1:0] lines,
                               input logic [NUM_IRQ-1:0] en,
                               input logic ack);
    irq    = lines;
    irqEn  = en;
    irqAck = ack;
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus('0, '1, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    stepCycle(1);
  endtask

  task automatic waitOffer(input int maxCycles, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      if (irqPending) begin
        seen = 1'b1;
        break;
      end
      stepCycle(1);
    end
  endtask

  logic        seen;
  logic [4:0]  expOrder [4];

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    applyStimulus('0, '1, 1'b0);

    // Reset values
    applyReset();
    checkOutput("rst_pending", 32'(irqPending), 32'd0);
    checkOutput("rst_id", 32'(irqId), 32'd0);
    checkOutput("rst_sec", 32'(irqSec), 32'd0);
    checkOutput("rst_vec", pendVec, 32'd0);

    // Edge line 5: rise, offer after two edges, ack clears pending, no re-offer
    applyStimulus(32'h0000_0020, '1, 1'b0);
    stepCycle(1);
    checkOutput("e5_notyet", 32'(irqPending), 32'd0);
    checkOutput("e5_vec", pendVec, 32'h0000_0020);
    stepCycle(1);
    checkOutput("e5_pending", 32'(irqPending), 32'd1);
    checkOutput("e5_id", 32'(irqId), 32'd5);
    applyStimulus(32'h0000_0020, '1, 1'b1);
    stepCycle(1);
    applyStimulus(32'h0000_0020, '1, 1'b0);
    checkOutput("e5_acked_pending", 32'(irqPending), 32'd0);
    checkOutput("e5_acked_vec", pendVec, 32'd0);
    stepCycle(1);
    checkOutput("e5_idle1", 32'(irqPending), 32'd0);
    stepCycle(1);
    checkOutput("e5_idle2", 32'(irqPending), 32'd0);

`ifndef RISCV_IRQ_ARB_RR_EN
    // Level lines 3 and 7: lowest wins, re-offers while high, then 7
    applyReset();
    applyStimulus(32'h0000_0088, '1, 1'b0);
    stepCycle(2);
    checkOutput("l37_id_first", 32'(irqId), 32'd3);
    checkOutput("l37_pending_first", 32'(irqPending), 32'd1);
    applyStimulus(32'h0000_0088, '1, 1'b1);
    stepCycle(1);
    applyStimulus(32'h0000_0088, '1, 1'b0);
    stepCycle(2);
    checkOutput("l37_reoffer", 32'(irqPending), 32'd1);
    checkOutput("l37_reoffer_id", 32'(irqId), 32'd3);
    applyStimulus(32'h0000_0080, '1, 1'b0);
    stepCycle(1);
    checkOutput("l37_hold", 32'(irqPending), 32'd1);
    stepCycle(1);
    checkOutput("l37_withdraw", 32'(irqPending), 32'd0);
    stepCycle(1);
    checkOutput("l37_id7", 32'(irqId), 32'd7);
    checkOutput("l37_id7_pending", 32'(irqPending), 32'd1);
    applyStimulus('0, '1, 1'b1);
    stepCycle(1);
    applyStimulus('0, '1, 1'b0);
    stepCycle(2);
    checkOutput("l37_clear", 32'(irqPending), 32'd0);
`endif

    // Level line 9: withdrawal by enable leaves pending bit, re-enable re-offers
    applyReset();
    applyStimulus(32'h0000_0200, '1, 1'b0);
    stepCycle(2);
    checkOutput("l9_id", 32'(irqId), 32'd9);
    applyStimulus(32'h0000_0200, 32'hFFFF_FDFF, 1'b0);
    stepCycle(1);
    checkOutput("l9_withdraw", 32'(irqPending), 32'd0);
    checkOutput("l9_vec", pendVec, 32'h0000_0200);
    applyStimulus(32'h0000_0200, '1, 1'b0);
    stepCycle(1);
    checkOutput("l9_reoffer", 32'(irqPending), 32'd1);
    checkOutput("l9_reoffer_id", 32'(irqId), 32'd9);

    // Edge line 2 re-rises on the ack edge: pending survives and re-offers
    applyReset();
    applyStimulus(32'h0000_0004, '1, 1'b0);
    stepCycle(1);
    applyStimulus('0, '1, 1'b0);
    stepCycle(1);
    checkOutput("e2_id", 32'(irqId), 32'd2);
    applyStimulus(32'h0000_0004, '1, 1'b1);
    stepCycle(1);
    applyStimulus(32'h0000_0004, '1, 1'b0);
    checkOutput("e2_acked", 32'(irqPending), 32'd0);
    checkOutput("e2_vec_kept", pendVec, 32'h0000_0004);
    stepCycle(2);
    checkOutput("e2_reoffer", 32'(irqPending), 32'd1);
    checkOutput("e2_reoffer_id", 32'(irqId), 32'd2);
    applyStimulus(32'h0000_0004, '1, 1'b1);
    stepCycle(1);
    applyStimulus('0, '1, 1'b0);
    checkOutput("e2_vec_cleared", pendVec, 32'd0);

    // Arbitration order with lines 1, 4, 6 held high and immediate acks
    applyReset();
`ifdef RISCV_IRQ_ARB_RR_EN
    expOrder = '{5'd1, 5'd4, 5'd6, 5'd1};
`else
    expOrder = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
    applyStimulus(32'h0000_0052, '1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      waitOffer(8, seen);
      checkOutput($sformatf("order_seen%0d", n), 32'(seen), 32'd1);
      checkOutput($sformatf("order_id%0d", n), 32'(irqId), 32'(expOrder[n]));
      applyStimulus(32'h0000_0052, '1, 1'b1);
      stepCycle(1);
      applyStimulus(32'h0000_0052, '1, 1'b0);
    end

    // Secure line 10, then asynchronous reset during an offer
    applyReset();
    applyStimulus(32'h0000_0400, '1, 1'b0);
    stepCycle(2);
    checkOutput("s10_id", 32'(irqId), 32'd10);
    checkOutput("s10_sec", 32'(irqSec), 32'd1);
    applyStimulus('0, '1, 1'b1);
    stepCycle(1);
    applyStimulus('0, '1, 1'b0);
    stepCycle(1);
    checkOutput("s10_sec_after", 32'(irqSec), 32'd0);
    applyStimulus(32'h0000_0400, '1, 1'b0);
    stepCycle(2);
    checkOutput("s10_offer_again", 32'(irqPending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_pending", 32'(irqPending), 32'd0);
    checkOutput("arst_id", 32'(irqId), 32'd0);
    checkOutput("arst_sec", 32'(irqSec), 32'd0);
    checkOutput("arst_vec", pendVec, 32'd0);
    stepCycle(2);
    checkOutput("arst_held_vec", pendVec, 32'd0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/riscv_irq_arbiter.md
# riscv_irq_arbiter

Collects the per-line interrupt sources of the core, records pending interrupts (level or edge), picks one winner by priority, and presents it as a single pending/id/secure triple to the core's interrupt controller. The selection is held stable until the core acknowledges it or the candidate disappears. The block sits between the SoC interrupt lines and the interrupt controller's `irq_pending_i` / `irq_id_i` / `irq_sec_i` inputs.

## Interface
- `NUM_IRQ`, default 32: number of interrupt lines, 1..32; ids are 0..NUM_IRQ-1.
- `EDGE_MASK`, default 32'h0000_0000: bit i=1 makes line i edge-triggered (rising); 0 makes it level-triggered.
- `SEC_MASK`, default 32'h0000_0000: bit i=1 marks line i as secure.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq_i` in NUM_IRQ: raw interrupt lines, synchronous to clk.
- `irq_en_i` in NUM_IRQ: per-line enable (CSR mask).
- `irq_ack_i` in 1: single-cycle acknowledge of the offered interrupt, from the core controller.
- `irq_pending_o` out 1: an interrupt is being offered.
- `irq_id_o` out 5: id of the offered interrupt.
- `irq_sec_o` out 1: secure bit of the offered interrupt.
- `irq_pend_vec_o` out NUM_IRQ: raw pending register, for the mip-style CSR read.

## Operation
- Registers: `irq_d` (previous irq_i), `pend_q[NUM_IRQ]`, `id_q[4:0]`, `sec_q`, state, and the RR pointer (Configuration).
- Pending update, every cycle:
  - Level line i: `pend_q[i] <= irq_i[i]`. Ack has no effect.
  - Edge line i: set on `irq_i[i] & ~irq_d[i]`. Cleared when an ack is accepted and `id_q == i`. Set wins over clear in the same cycle.
- Candidates: `cand = pend_q & irq_en_i`.
- Winner: in fixed-priority mode, the lowest-index set bit of `cand`.
- FSM states:
  - IDLE: if `cand != 0`, latch the winner into `id_q`, set `sec_q <= SEC_MASK[winner]`, go to OFFER. Otherwise stay.
  - OFFER:
    - If `irq_ack_i`, go to ACKED (clear `pend_q[id_q]` if it is an edge line).
    - Otherwise, if `cand[id_q] == 0` (enable dropped, or level line fell), go to IDLE. This is a withdrawal; no pending bit is changed.
    - Otherwise stay. `id_q` and `sec_q` are frozen, even if a higher-priority line arrives.
  - ACKED: one blanking cycle, then go to IDLE unconditionally. `sec_q <= 0`.
- Outputs:
  - `irq_pending_o = (state == OFFER)`.
  - `irq_id_o = id_q`.
  - `irq_sec_o = sec_q`.
  - `irq_pend_vec_o = pend_q`.
- `irq_ack_i` outside OFFER is ignored.
- If `irq_ack_i` and the withdraw condition occur together in OFFER, the ack wins.
- Reset values: all outputs 0, `pend_q = 0`, `irq_d = 0`, `id_q = 0`, `sec_q = 0`, state IDLE.
- Reset mid-OFFER drops the offer immediately; edge pendings are lost.

## Timing
- Line sampled rising at clock edge k → `pend_q` set after edge k → OFFER after edge k+1. `irq_pending_o` is high 2 cycles after the sampled edge, with the id valid in the same cycle.
- Ack sampled at edge m: `irq_pending_o` low after m (ACKED), IDLE after m+1. A new offer can appear after m+2 at the earliest.
- Back-to-back offers are therefore separated by at least 2 low cycles of `irq_pending_o`.
- Withdraw: `irq_pending_o` drops one cycle after `cand[id_q]` falls.
- A level line re-offers after ack for as long as it stays high. The source must deassert it.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `RISCV_IRQ_ARB_RR_EN` defined: round-robin selection.
  - Pointer `last_q` resets to NUM_IRQ-1.
  - The search starts at `last_q+1`, wraps modulo NUM_IRQ, and picks the first set bit of `cand`.
  - `last_q <= id_q` on an accepted ack. A withdrawal does not move the pointer.
- Not defined: fixed lowest-index priority; the pointer logic is absent.
- With a single candidate, both modes pick the same id.

## Test plan
- Reset, then drive edge line 5 (EDGE_MASK[5]=1, en=all 1s) from 0→1 at edge k → `irq_pending_o=1`, `irq_id_o=5` after k+1. Ack → `pend_q[5]=0`, `irq_pending_o` low for 2 cycles, no re-offer.
- Level lines 3 and 7 high together, fixed priority → id 3 offered. Ack with line 3 still high → id 3 re-offered. Drop line 3 → id 7 offered.
- Offer id 9, then clear `irq_en_i[9]` → `irq_pending_o` low next cycle, `pend_q[9]` still 1. Re-enable → id 9 re-offered.
- Edge line 2 re-rises in the same cycle its ack is accepted → `pend_q[2]` stays 1, and id 2 is offered again after ACKED/IDLE.
- `RISCV_IRQ_ARB_RR_EN` defined, level lines 1, 4 and 6 held high with immediate acks → offer order 1, 4, 6, 1.
- SEC_MASK[10]=1 and line 10 raised → `irq_sec_o=1` with `irq_id_o=10`; `irq_sec_o=0` after ACKED. Assert `rst_n` low during OFFER → all outputs 0 asynchronously.
